// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI bus sequencer: FSM state encoding,
// HPI register-select codes and the phase-counter load helper.
package hpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } hpi_state_e;

    localparam logic [1:0] DATA    = 2'd0;
    localparam logic [1:0] MAILBOX = 2'd1;
    localparam logic [1:0] ADDRESS = 2'd2;
    localparam logic [1:0] STATUS  = 2'd3;

    // The down-counter expires at zero, so a phase of N cycles loads N-1.
    function automatic logic [3:0] phase_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/hpi_sync2.sv
// Two-flop synchronizer for the asynchronous HPI interrupt line.
// Only compiled when HPI_IRQ_SYNC_EN is defined; otherwise no synchronizer exists.
`ifdef HPI_IRQ_SYNC_EN
module hpi_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`endif

// File: rtl/hpi_bus_sequencer.sv
// Avalon-slave to HPI bus sequencer: stretches each access into SETUP/STROBE/HOLD/RECOVER
// phases. Define HPI_IRQ_SYNC_EN to forward otg_int to irq through hpi_sync2.
module hpi_bus_sequencer
    import hpi_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    input  logic        otg_int,
    output logic        irq
);

    hpi_state_e  r_state;
    hpi_state_e  w_next_state;
    logic [3:0]  r_count;
    logic [3:0]  w_next_count;
    logic [1:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_is_write;
    logic [15:0] r_readdata;
    logic        w_request;
    logic        w_count_done;
    logic        w_active;

    assign w_request    = avs_read | avs_write;
    assign w_count_done = (r_count == 4'd0);
    assign w_active     = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);

    // Requests are latched only in IDLE so the master may change its inputs mid-access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_addr     <= 2'd0;
            r_wdata    <= 16'd0;
            r_is_write <= 1'b0;
            r_readdata <= 16'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (r_state == ST_IDLE && w_request) begin
                r_addr     <= avs_address;
                r_wdata    <= avs_writedata;
                r_is_write <= avs_write;
            end
            if (r_state == ST_STROBE && w_count_done && !r_is_write) begin
                r_readdata <= otg_data_in;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = w_count_done ? 4'd0 : r_count - 4'd1;
        case (r_state)
            ST_IDLE: begin
                w_next_count = 4'd0;
                if (w_request) begin
                    w_next_state = ST_SETUP;
                    w_next_count = phase_load(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (w_count_done) begin
                    w_next_state = ST_STROBE;
                    w_next_count = phase_load(STROBE_CYC);
                end
            end
            ST_STROBE: begin
                if (w_count_done) begin
                    w_next_state = ST_HOLD;
                    w_next_count = phase_load(HOLD_CYC);
                end
            end
            ST_HOLD: begin
                if (w_count_done) begin
                    w_next_state = ST_RECOVER;
                    w_next_count = phase_load(RECOVER_CYC);
                end
            end
            ST_RECOVER: begin
                if (w_count_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_count = 4'd0;
            end
        endcase
    end

    always_comb begin
        otg_cs_n     = 1'b1;
        otg_rd_n     = 1'b1;
        otg_wr_n     = 1'b1;
        otg_addr     = 2'd0;
        otg_data_out = 16'd0;
        otg_data_oe  = 1'b0;
        if (w_active) begin
            otg_cs_n = 1'b0;
            otg_addr = r_addr;
            if (r_is_write) begin
                otg_data_oe  = 1'b1;
                otg_data_out = r_wdata;
            end
        end
        if (r_state == ST_STROBE) begin
            if (r_is_write) begin
                otg_wr_n = 1'b0;
            end else begin
                otg_rd_n = 1'b0;
            end
        end
        avs_waitrequest = w_request & ~(r_state == ST_RECOVER && w_count_done);
    end

    assign avs_readdata = r_readdata;

`ifdef HPI_IRQ_SYNC_EN
    hpi_sync2 u_irq_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (otg_int),
        .o_sync  (irq)
    );
`else
    logic w_unused_otg_int;
    assign w_unused_otg_int = otg_int;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Self-checking bench for hpi_bus_sequencer: vector table, randomized accesses against a
// cycle-timeline model, and hand-written reset, back-to-back and interrupt sequences.
module tb_hpi_bus_sequencer;
    import hpi_pkg::*;

    localparam int S     = 1;
    localparam int ST    = 4;
    localparam int H     = 1;
    localparam int R     = 2;
    localparam int TOTAL = S + ST + H + R;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic [1:0]  otg_addr;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic        otg_int;
    logic        irq;

    int          assertions = 0;
    int          failures   = 0;
    logic [15:0] modelReaddata = 16'd0;

    int   cycleCount = 0;
    int   riseCycle  = 0;
    int   fallCycle  = 0;
    logic csPrev     = 1'b1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic        expWrite;
        logic [15:0] expReaddata;
    } vector_t;

    vector_t vectors [5];

    hpi_bus_sequencer #(
        .SETUP_CYC   (S),
        .STROBE_CYC  (ST),
        .HOLD_CYC    (H),
        .RECOVER_CYC (R)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .otg_addr        (otg_addr),
        .otg_data_out    (otg_data_out),
        .otg_data_oe     (otg_data_oe),
        .otg_data_in     (otg_data_in),
        .otg_cs_n        (otg_cs_n),
        .otg_rd_n        (otg_rd_n),
        .otg_wr_n        (otg_wr_n),
        .otg_int         (otg_int),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge tracker on cs_n, sampled mid-cycle, used for the recovery-gap measurement.
    always @(negedge clk) begin
        cycleCount = cycleCount + 1;
        if (csPrev == 1'b0 && otg_cs_n == 1'b1) riseCycle = cycleCount;
        if (csPrev == 1'b1 && otg_cs_n == 1'b0) fallCycle = cycleCount;
        csPrev = otg_cs_n;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected bus state for cycle t of an access, t=0 being the request cycle in IDLE.
    task automatic checkCycle(input int t, input logic isWrite, input logic [1:0] a,
                              input logic [15:0] wd, input logic [15:0] din);
        logic        active;
        logic        strobe;
        logic [15:0] expRd;
        active = (t >= 1) && (t <= S + ST + H);
        strobe = (t >= S + 1) && (t <= S + ST);
        expRd  = (!isWrite && t > S + ST) ? din : modelReaddata;
        checkOutput("cs_n",        otg_cs_n,        !active);
        checkOutput("rd_n",        otg_rd_n,        !(strobe && !isWrite));
        checkOutput("wr_n",        otg_wr_n,        !(strobe && isWrite));
        checkOutput("otg_addr",    otg_addr,        active ? a : 2'd0);
        checkOutput("data_oe",     otg_data_oe,     active && isWrite);
        checkOutput("data_out",    otg_data_out,    (active && isWrite) ? wd : 16'd0);
        checkOutput("waitrequest", avs_waitrequest, t != TOTAL);
        checkOutput("readdata",    avs_readdata,    expRd);
`ifndef HPI_IRQ_SYNC_EN
        checkOutput("irq_tied",    irq,             1'b0);
`endif
    endtask

    // Runs one full access starting just after a rising edge; optionally scrambles inputs mid-access.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] a,
                                 input logic [15:0] wd, input logic [15:0] din, input bit scramble);
        logic isWrite;
        isWrite       = wr;
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = a;
        avs_writedata = wd;
        for (int t = 0; t <= TOTAL; t++) begin
            otg_data_in = (t == S + ST) ? din : ~din;
            if (scramble && t > 0) begin
                avs_address   = 2'($urandom);
                avs_writedata = 16'($urandom);
            end
            @(negedge clk);
            checkCycle(t, isWrite, a, wd, din);
            @(posedge clk);
            #1;
        end
        if (!isWrite) modelReaddata = din;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("idle_cs_n",  otg_cs_n,        1'b1);
            checkOutput("idle_strb",  {otg_rd_n, otg_wr_n}, 2'b11);
            checkOutput("idle_oe",    otg_data_oe,     1'b0);
            checkOutput("idle_wait",  avs_waitrequest, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic rd;
        logic wr;
        int   rise1;

        vectors[0] = '{rd: 1'b0, wr: 1'b1, addr: ADDRESS, wdata: 16'h1234, din: 16'h5555, expWrite: 1'b1, expReaddata: 16'h0000};
        vectors[1] = '{rd: 1'b1, wr: 1'b0, addr: DATA,    wdata: 16'h0000, din: 16'hBEEF, expWrite: 1'b0, expReaddata: 16'hBEEF};
        vectors[2] = '{rd: 1'b1, wr: 1'b1, addr: MAILBOX, wdata: 16'hA5A5, din: 16'h1111, expWrite: 1'b1, expReaddata: 16'hBEEF};
        vectors[3] = '{rd: 1'b1, wr: 1'b0, addr: STATUS,  wdata: 16'h7777, din: 16'h0F0F, expWrite: 1'b0, expReaddata: 16'h0F0F};
        vectors[4] = '{rd: 1'b0, wr: 1'b1, addr: DATA,    wdata: 16'hFFFF, din: 16'h2222, expWrite: 1'b1, expReaddata: 16'h0F0F};

        reset_n       = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 16'd0;
        otg_data_in   = 16'd0;
        otg_int       = 1'b0;

        #12;
        checkOutput("rst_cs_n",     otg_cs_n,     1'b1);
        checkOutput("rst_strobes",  {otg_rd_n, otg_wr_n}, 2'b11);
        checkOutput("rst_oe",       otg_data_oe,  1'b0);
        checkOutput("rst_addr",     otg_addr,     2'd0);
        checkOutput("rst_data_out", otg_data_out, 16'd0);
        checkOutput("rst_readdata", avs_readdata, 16'd0);
        checkOutput("rst_irq",      irq,          1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idleCycles(2);

        $display("[TB] vector table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vectors[i].rd, vectors[i].wr, vectors[i].addr,
                          vectors[i].wdata, vectors[i].din, 1'b0);
            checkOutput("vec_readdata", avs_readdata, vectors[i].expReaddata);
            checkOutput("vec_strobe_kind", vectors[i].expWrite, vectors[i].wr);
            idleCycles(1);
        end

        $display("[TB] back-to-back write then read");
        applyStimulus(1'b0, 1'b1, ADDRESS, 16'hCAFE, 16'h0000, 1'b0);
        rise1 = riseCycle;
        applyStimulus(1'b1, 1'b0, DATA, 16'h0000, 16'h4321, 1'b0);
        checkOutput("b2b_gap", 32'(fallCycle - rise1), 32'(R + 1));
        idleCycles(1);

        $display("[TB] reset during write");
        avs_read      = 1'b0;
        avs_write     = 1'b1;
        avs_address   = ADDRESS;
        avs_writedata = 16'h1234;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checkCycle(t, 1'b1, ADDRESS, 16'h1234, 16'h0000);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("pre_rst_wr_n", otg_wr_n, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_cs_n",  otg_cs_n,        1'b1);
        checkOutput("mid_rst_wr_n",  otg_wr_n,        1'b1);
        checkOutput("mid_rst_oe",    otg_data_oe,     1'b0);
        checkOutput("mid_rst_addr",  otg_addr,        2'd0);
        checkOutput("mid_rst_rdata", avs_readdata,    16'd0);
        checkOutput("mid_rst_wait",  avs_waitrequest, 1'b1);
        modelReaddata = 16'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b1, ADDRESS, 16'h1234, 16'h0000, 1'b0);
        idleCycles(1);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 16; n++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            applyStimulus(rd, wr, 2'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            idleCycles(int'($urandom_range(0, 2)));
        end

        $display("[TB] interrupt path");
        otg_int = 1'b1;
        @(negedge clk);
        checkOutput("irq_edge0", irq, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("irq_edge1", irq, 1'b0);
        @(posedge clk);
        @(negedge clk);
`ifdef HPI_IRQ_SYNC_EN
        checkOutput("irq_edge2", irq, 1'b1);
`else
        checkOutput("irq_edge2", irq, 1'b0);
`endif
        otg_int = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("irq_fall", irq, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/hpi_bus_sequencer.md
HPI_BUS_SEQUENCER -- requirements
Module: hpi_bus_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1, meaning cycles with cs_n low and address stable before strobe (range 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 4, meaning rd_n/wr_n low width in cycles (range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1, meaning cycles after strobe release with address/data held (range 1..15).
REQ-004 SHALL have parameter RECOVER_CYC, default 2, meaning cycles with cs_n high before the next access (range 1..15).
REQ-005 SHALL have port clk, input, 1, system clock; reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports avs_address (input, 2, HPI register select: 0 data, 1 mailbox, 2 address, 3 status), avs_read (input, 1), avs_write (input, 1) and avs_writedata (input, 16).
REQ-007 SHALL have ports avs_readdata (output, 16) and avs_waitrequest (output, 1).
REQ-008 SHALL have ports otg_addr (output, 2), otg_data_out (output, 16), otg_data_oe (output, 1), otg_data_in (input, 16), otg_cs_n (output, 1), otg_rd_n (output, 1) and otg_wr_n (output, 1).
REQ-009 SHALL have ports otg_int (input, 1, asynchronous HPI interrupt) and irq (output, 1).

Function
REQ-010 SHALL implement FSM IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE, with each phase lasting exactly its parameter count of cycles.
REQ-011 SHALL, in IDLE with avs_read or avs_write high, latch address, direction and writedata, then enter SETUP the next cycle.
REQ-012 SHALL treat simultaneous avs_read and avs_write as a write.
REQ-013 SHALL drive avs_waitrequest = (avs_read | avs_write) & ~(final RECOVER cycle), combinationally.
REQ-014 SHALL complete the transfer (waitrequest low) on cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+RECOVER_CYC, counting the first request cycle as 0 (default: cycle 8).
REQ-015 SHALL hold otg_cs_n low during SETUP, STROBE and HOLD only, and high otherwise.
REQ-016 SHALL hold otg_rd_n (read) or otg_wr_n (write) low during STROBE only; never both.
REQ-017 SHALL drive otg_addr from the latched address during SETUP..HOLD, and 0 otherwise.
REQ-018 SHALL, for writes, assert otg_data_oe and drive otg_data_out with latched data during SETUP..HOLD; otg_data_oe SHALL be 0 in all other states and for all reads.
REQ-019 SHALL capture otg_data_in on the last STROBE cycle of a read into a readdata register; avs_readdata SHALL present that register and hold it until the next read capture.
REQ-020 SHALL ignore request changes between acceptance and completion; a new request is accepted only from IDLE.

Reset
REQ-021 SHALL asynchronously force state IDLE, otg_cs_n/otg_rd_n/otg_wr_n = 1, otg_data_oe = 0, otg_addr = 0, otg_data_out = 0, avs_readdata = 0, irq = 0 on reset_n low.
REQ-022 SHALL, on reset mid-transaction, release all strobes immediately and discard the transaction; after reset release, waitrequest follows REQ-013 from IDLE.

Configuration
REQ-023 SHALL, with macro HPI_IRQ_SYNC_EN defined, drive irq from otg_int through a two-flop synchronizer (2-cycle latency, both flops reset to 0).
REQ-024 SHALL, without HPI_IRQ_SYNC_EN, tie irq to 0 and instantiate no synchronizer.

Structure
REQ-025 SHALL place the FSM state enum and HPI register-select constants (DATA=0, MAILBOX=1, ADDRESS=2, STATUS=3) in shared package hpi_pkg.
REQ-026 SHALL implement the synchronizer as sub-module hpi_sync2; phase timing uses a single 4-bit down-counter within this block.

Verification
REQ-027 SHALL verify default write: avs_write=1, address=2, data=0x1234 -> cs_n low cycles 1-6, wr_n low cycles 2-5, otg_data_out=0x1234 with oe high cycles 1-6, waitrequest low cycle 8.
REQ-028 SHALL verify default read: address=0, otg_data_in=0xBEEF during strobe -> rd_n low cycles 2-5, avs_readdata=0xBEEF on cycle 8 with waitrequest low.
REQ-029 SHALL verify back-to-back: write then read held continuously -> second cs_n falling edge exactly RECOVER_CYC+1 cycles after first cs_n rising edge.
REQ-030 SHALL verify reset asserted in cycle 3 of a write -> cs_n, wr_n = 1 and oe = 0 within the same cycle; after release the held request restarts from cycle 0.
REQ-031 SHALL verify simultaneous read+write -> wr_n strobes and rd_n stays 1.
REQ-032 SHALL verify with HPI_IRQ_SYNC_EN: otg_int rising -> irq high on the 2nd clock edge; without the macro, irq stays 0.
